// File: rtl/ps2_keyb_matrix.sv
// PS/2 set-2 keyboard front end: filtered frame receiver, E0/F0 prefix decoder and 8x5 Spectrum key matrix.
// Matrix and scan outputs update on the edge that samples the stop bit; kbd is combinational from a_hi.
module ps2_keyb_matrix #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 14000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic [7:0] a_hi,
  output logic [4:0] kbd,
  output logic       scan_valid,
  output logic [7:0] scancode,
  output logic       released,
  output logic       extended,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_f;
  logic [FW-1:0] fcnt;
  logic          fe;
  state_t        state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          rel, ext;
  logic [39:0]   mat;
  logic [39:0]   cur_mask;

  // Matrix bit index is row*5 + column.
  function automatic logic [39:0] key_mask(input logic [7:0] code, input logic is_ext);
    logic [39:0] m;
    m = '0;
    if (is_ext) begin
      case (code)
        8'h6B: begin m[0] = 1'b1; m[19] = 1'b1; end
        8'h72: begin m[0] = 1'b1; m[24] = 1'b1; end
        8'h75: begin m[0] = 1'b1; m[23] = 1'b1; end
        8'h74: begin m[0] = 1'b1; m[22] = 1'b1; end
        default: ;
      endcase
    end else begin
      case (code)
        8'h12: m[0] = 1'b1;   8'h1A: m[1] = 1'b1;   8'h22: m[2] = 1'b1;
        8'h21: m[3] = 1'b1;   8'h2A: m[4] = 1'b1;   8'h1C: m[5] = 1'b1;
        8'h1B: m[6] = 1'b1;   8'h23: m[7] = 1'b1;   8'h2B: m[8] = 1'b1;
        8'h34: m[9] = 1'b1;   8'h15: m[10] = 1'b1;  8'h1D: m[11] = 1'b1;
        8'h24: m[12] = 1'b1;  8'h2D: m[13] = 1'b1;  8'h2C: m[14] = 1'b1;
        8'h16: m[15] = 1'b1;  8'h1E: m[16] = 1'b1;  8'h26: m[17] = 1'b1;
        8'h25: m[18] = 1'b1;  8'h2E: m[19] = 1'b1;  8'h45: m[20] = 1'b1;
        8'h46: m[21] = 1'b1;  8'h3E: m[22] = 1'b1;  8'h3D: m[23] = 1'b1;
        8'h36: m[24] = 1'b1;  8'h4D: m[25] = 1'b1;  8'h44: m[26] = 1'b1;
        8'h43: m[27] = 1'b1;  8'h3C: m[28] = 1'b1;  8'h35: m[29] = 1'b1;
        8'h5A: m[30] = 1'b1;  8'h4B: m[31] = 1'b1;  8'h42: m[32] = 1'b1;
        8'h3B: m[33] = 1'b1;  8'h33: m[34] = 1'b1;  8'h29: m[35] = 1'b1;
        8'h14: m[36] = 1'b1;  8'h3A: m[37] = 1'b1;  8'h31: m[38] = 1'b1;
        8'h32: m[39] = 1'b1;
        8'h66: begin m[0] = 1'b1; m[20] = 1'b1; end
        default: ;
      endcase
    end
    return m;
  endfunction

  assign cur_mask = key_mask(shreg, ext);

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2data;
      dat_s2 <= dat_s1;
    end
  end

  // A new clock level is accepted only after FILTER consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_f <= 1'b1;
      fcnt  <= '0;
    end else if (clk_s2 == clk_f) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILTER - 1)) begin
      clk_f <= clk_s2;
      fcnt  <= '0;
    end else begin
      fcnt <= fcnt + FW'(1);
    end
  end

  assign fe = (clk_s2 != clk_f) && (fcnt == FW'(FILTER - 1)) && !clk_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      rel        <= 1'b0;
      ext        <= 1'b0;
      mat        <= '1;
      scan_valid <= 1'b0;
      scancode   <= '0;
      released   <= 1'b0;
      extended   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE || fe) tcnt <= '0;
      else                     tcnt <= tcnt + TW'(1);

      if (state != IDLE && !fe && tcnt == TW'(TIMEOUT)) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end else if (fe) begin
        case (state)
          IDLE: if (!dat_s2) begin
            state  <= DATA;
            bitcnt <= '0;
          end
          DATA: begin
            shreg  <= {dat_s2, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= dat_s2;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat_s2 && (^{shreg, par_bit})) begin
              if (shreg == 8'hF0) begin
                rel <= 1'b1;
              end else if (shreg == 8'hE0) begin
                ext <= 1'b1;
              end else if (shreg == 8'h00 || shreg == 8'hFF) begin
                mat <= '1;
                rel <= 1'b0;
                ext <= 1'b0;
              end else begin
                mat        <= rel ? (mat | cur_mask) : (mat & ~cur_mask);
                scan_valid <= 1'b1;
                scancode   <= shreg;
                released   <= rel;
                extended   <= ext;
                rel        <= 1'b0;
                ext        <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
              rel       <= 1'b0;
              ext       <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    kbd = '1;
    for (int i = 0; i < 8; i++) begin
      if (!a_hi[i]) kbd = kbd & mat[i*5 +: 5];
    end
  end

endmodule

// File: tb/tb_ps2_keyb_matrix.sv
// Randomized scoreboard bench for ps2_keyb_matrix against a key-name based reference model.
module tb_ps2_keyb_matrix;

  localparam int HALF = 20;
  localparam int TMO  = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2clk = 1'b1;
  logic       ps2data = 1'b1;
  logic [7:0] a_hi = 8'hFF;
  logic [4:0] kbd;
  logic       scan_valid, released, extended, frame_err;
  logic [7:0] scancode;

  ps2_keyb_matrix #(.FILTER(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ps2clk(ps2clk), .ps2data(ps2data), .a_hi(a_hi),
    .kbd(kbd), .scan_valid(scan_valid), .scancode(scancode),
    .released(released), .extended(extended), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    bit         rel;
    bit         ext;
  } ev_t;

  ev_t   exp_q[$];
  int    tests = 0;
  int    fails = 0;
  string names[40];
  int    m1[int];
  int    m2[int];
  bit    pressed[40];
  bit    m_rel, m_ext;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int pos(input string n);
    for (int i = 0; i < 40; i++) if (names[i] == n) return i;
    return -1;
  endfunction

  task automatic add_key(input int code, input string k1, input string k2);
    m1[code] = pos(k1);
    if (k2 != "") m2[code] = pos(k2);
  endtask

  function automatic logic [4:0] model_kbd(input logic [7:0] a);
    logic [4:0] r;
    r = 5'h1F;
    for (int row = 0; row < 8; row++)
      if (!a[row])
        for (int c = 0; c < 5; c++)
          if (pressed[row*5 + c]) r[c] = 1'b0;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 40; i++) pressed[i] = 1'b0;
    m_rel = 1'b0;
    m_ext = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    ev_t e;
    int  k;
    e.is_err = !good; e.code = b; e.rel = m_rel; e.ext = m_ext;
    if (!good) begin
      exp_q.push_back(e);
      m_rel = 1'b0; m_ext = 1'b0;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'h00 || b == 8'hFF) begin
      model_clear();
    end else begin
      k = m_ext ? 256 + int'(b) : int'(b);
      if (m1.exists(k)) pressed[m1[k]] = !m_rel;
      if (m2.exists(k)) pressed[m2[k]] = !m_rel;
      exp_q.push_back(e);
      m_rel = 1'b0; m_ext = 1'b0;
    end
  endtask

  task automatic clock_bit(input logic v);
    ps2data = v;
    repeat (HALF) @(posedge clk);
    ps2clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    model_byte(b, !(bad_par || bad_stop));
    p = ~(^b) ^ bad_par;
    clock_bit(1'b0);
    for (int i = 0; i < 8; i++) clock_bit(b[i]);
    clock_bit(p);
    clock_bit(!bad_stop);
    ps2data = 1'b1;
    repeat (3*HALF) @(posedge clk);
    check("sb_drain", exp_q.size(), 0);
  endtask

  task automatic check_kbd(input logic [7:0] a);
    a_hi = a;
    #1;
    check("kbd_model", kbd, model_kbd(a));
  endtask

  task automatic check_const(input string name, input logic [7:0] a, input logic [4:0] exp);
    a_hi = a;
    #1;
    check(name, kbd, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    model_clear();
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expected event per scan_valid or frame_err pulse.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst && (scan_valid || frame_err)) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_event: got sv=%b fe=%b code=%h expected no event", scan_valid, frame_err, scancode);
        end else begin
          e = exp_q.pop_front();
          check("ev_err", {scan_valid, frame_err}, {!e.is_err, e.is_err});
          if (!e.is_err)
            check("ev_scan", {scancode, released, extended}, {e.code, e.rel, e.ext});
        end
      end
    end
  end

  initial begin
    logic [7:0] pool[20];
    logic [7:0] b;
    bit         bad;
    names = '{"CS","Z","X","C","V", "A","S","D","F","G", "Q","W","E","R","T",
              "1","2","3","4","5", "0","9","8","7","6", "P","O","I","U","Y",
              "ENTER","L","K","J","H", "SPACE","SS","M","N","B"};
    add_key('h1C,"A",""); add_key('h32,"B",""); add_key('h21,"C",""); add_key('h23,"D","");
    add_key('h24,"E",""); add_key('h2B,"F",""); add_key('h34,"G",""); add_key('h33,"H","");
    add_key('h43,"I",""); add_key('h3B,"J",""); add_key('h42,"K",""); add_key('h4B,"L","");
    add_key('h3A,"M",""); add_key('h31,"N",""); add_key('h44,"O",""); add_key('h4D,"P","");
    add_key('h15,"Q",""); add_key('h2D,"R",""); add_key('h1B,"S",""); add_key('h2C,"T","");
    add_key('h3C,"U",""); add_key('h2A,"V",""); add_key('h1D,"W",""); add_key('h22,"X","");
    add_key('h35,"Y",""); add_key('h1A,"Z","");
    add_key('h16,"1",""); add_key('h1E,"2",""); add_key('h26,"3",""); add_key('h25,"4","");
    add_key('h2E,"5",""); add_key('h36,"6",""); add_key('h3D,"7",""); add_key('h3E,"8","");
    add_key('h46,"9",""); add_key('h45,"0","");
    add_key('h12,"CS",""); add_key('h14,"SS",""); add_key('h29,"SPACE",""); add_key('h5A,"ENTER","");
    add_key('h66,"CS","0");
    add_key(256+'h6B,"CS","5"); add_key(256+'h72,"CS","6");
    add_key(256+'h75,"CS","7"); add_key(256+'h74,"CS","8");

    do_reset();
    check("rst_outs", {scan_valid, scancode, released, extended, frame_err}, 12'h0);
    check_const("rst_kbd_00", 8'h00, 5'h1F);
    check_const("rst_kbd_ff", 8'hFF, 5'h1F);

    send_frame(8'h1C, 0, 0);
    check_const("a_press_fd", 8'hFD, 5'h1E);
    check_const("a_press_ff", 8'hFF, 5'h1F);

    send_frame(8'hF0, 0, 0); send_frame(8'h1C, 0, 0);
    check_const("a_rel_fd", 8'hFD, 5'h1F);
    send_frame(8'hE0, 0, 0); send_frame(8'h6B, 0, 0);
    check_const("left_fe", 8'hFE, 5'h1E);
    check_const("left_f7", 8'hF7, 5'h0F);

    send_frame(8'h1C, 1, 0);
    check_const("badpar_fd", 8'hFD, 5'h1F);
    send_frame(8'h1C, 0, 1);
    check_const("badstop_fd", 8'hFD, 5'h1F);

    // Partial frame left to time out.
    exp_q.push_back('{1'b1, 8'h00, 1'b0, 1'b0});
    clock_bit(1'b0);
    for (int i = 0; i < 4; i++) clock_bit(i[0]);
    ps2data = 1'b1;
    repeat (TMO + 200) @(posedge clk);
    check("tmo_drain", exp_q.size(), 0);
    send_frame(8'h29, 0, 0);
    check_const("space_7f", 8'h7F, 5'h1E);

    send_frame(8'h1A, 0, 0); send_frame(8'h45, 0, 0); send_frame(8'h5A, 0, 0);
    check_kbd(8'h00);
    send_frame(8'hFF, 0, 0);
    check_const("overrun_00", 8'h00, 5'h1F);

    send_frame(8'h1C, 0, 0); send_frame(8'h15, 0, 0);
    check_const("aq_f9", 8'hF9, 5'h1E);

    // Short clock glitch with data low must not look like a start bit.
    ps2data = 1'b0;
    ps2clk = 1'b0;
    repeat (3) @(posedge clk);
    ps2clk = 1'b1;
    repeat (50) @(posedge clk);
    ps2data = 1'b1;
    repeat (HALF) @(posedge clk);
    send_frame(8'h1A, 0, 0);
    check_kbd(8'hFE);

    pool = '{8'h1C, 8'h1A, 8'h16, 8'h45, 8'h12, 8'h14, 8'h29, 8'h5A, 8'h66, 8'h15,
             8'h3A, 8'h32, 8'hF0, 8'hF0, 8'hE0, 8'h6B, 8'h72, 8'h75, 8'h74, 8'h0E};
    for (int n = 0; n < 50; n++) begin
      b   = ($urandom_range(0, 29) == 0) ? 8'hFF : pool[$urandom_range(0, 19)];
      bad = ($urandom_range(0, 9) == 0);
      send_frame(b, bad && $urandom_range(0, 1) == 0, bad);
      check_kbd(8'($urandom_range(0, 255)));
      check_kbd(~(8'h01 << $urandom_range(0, 7)));
    end

    // Reset in the middle of a frame drops it silently.
    clock_bit(1'b0);
    clock_bit(1'b1);
    clock_bit(1'b0);
    ps2data = 1'b1;
    do_reset();
    repeat (TMO + 200) @(posedge clk);
    #1;
    check("midrst_outs", {scan_valid, scancode, released, extended, frame_err}, 12'h0);
    check_const("midrst_kbd", 8'h00, 5'h1F);
    send_frame(8'h32, 0, 0);
    check_kbd(8'h7F);

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_keyb_matrix.md
# ps2_keyb_matrix

PS/2 keyboard front end that feeds the ULA's keyboard half-row input. It receives PS/2 frames from a host keyboard and decodes set-2 scan codes, including the E0 (extended) and F0 (break) prefixes. It keeps an 8×5 ZX Spectrum key matrix and answers half-row reads addressed by A[15:8] with the active-low `kbd[4:0]` value the ULA returns on port 0xFE reads.

## Interface
Parameters:
- `FILTER`, 8: consecutive identical samples needed before a synchronized `ps2clk` level is accepted.
- `TIMEOUT`, 14000: `clk` cycles without a falling edge, while mid-frame, before the frame is aborted (about 1 ms at 14 MHz).

Ports:
- `clk`  in  1  system clock; all state advances on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `ps2clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2data`  in  1  raw PS/2 data, asynchronous.
- `a_hi`  in  8  CPU address A[15:8]; a bit at 0 selects that half-row.
- `kbd`  out  5  active-low column data; bit 0 is the outermost key.
- `scan_valid`  out  1  one-cycle pulse when a non-prefix byte has been applied.
- `scancode`  out  8  last non-prefix byte; valid while `scan_valid` is high and held afterwards.
- `released`  out  1  F0 prefix state for that byte; qualified by `scan_valid`.
- `extended`  out  1  E0 prefix state for that byte; qualified by `scan_valid`.
- `frame_err`  out  1  one-cycle pulse on a parity error, stop-bit error or timeout.

## Operation
Input conditioning:
- `ps2clk` and `ps2data` each pass through a 2-FF synchronizer.
- The synchronized `ps2clk` then goes through a glitch filter of `FILTER` samples.
- A falling edge of the filtered clock (the "fe" event) samples the synchronized `ps2data`.

Frame FSM, states IDLE → DATA → PARITY → STOP → IDLE:
- IDLE: on fe with data=0 (start bit), go to DATA and clear the bit counter. On fe with data=1, stay in IDLE with no error.
- DATA: shift in 8 bits, LSB first. After the 8th bit, go to PARITY.
- PARITY: latch the bit. The frame is good only if the count of ones across data plus parity is odd.
- STOP: on fe, if stop=1 and parity is good, deliver the byte to the decoder. Otherwise pulse `frame_err`, discard the byte and clear both prefix flags. Return to IDLE either way.
- Timeout counter: cleared on every fe and held at 0 in IDLE. When it reaches `TIMEOUT` in any other state, go to IDLE and pulse `frame_err`. The prefix flags are kept.

Decoder, per delivered byte:
- F0: set the `rel` flag.
- E0: set the `ext` flag.
- 00 or FF (overrun): set every matrix bit to 1 (all keys released) and clear both flags. `scan_valid` does not pulse.
- Any other byte: look it up in the map. For each mapped matrix bit, write 0 when `rel`=0 (press) and 1 when `rel`=1 (release). Pulse `scan_valid` with `scancode`, `released`=`rel` and `extended`=`ext`, then clear both flags. An unmapped code still pulses `scan_valid` but leaves the matrix unchanged.

Matrix rows, bit 0 first:
- r0: CS, Z, X, C, V
- r1: A, S, D, F, G
- r2: Q, W, E, R, T
- r3: 1, 2, 3, 4, 5
- r4: 0, 9, 8, 7, 6
- r5: P, O, I, U, Y
- r6: ENTER, L, K, J, H
- r7: SPACE, SS, M, N, B

Map:
- Letters and digits map to their Spectrum keys using standard set-2 codes, e.g. A=1C, Z=1A, 1=16, 0=45.
- 12 (L-Shift) → CS. 14 (L-Ctrl) → SS. 29 → SPACE. 5A → ENTER.
- 66 (Backspace) → CS + 0.
- E0 prefix: 6B (Left) → CS+5, 72 (Down) → CS+6, 75 (Up) → CS+7, 74 (Right) → CS+8.
- An E0-prefixed code not listed above is unmapped.
- Keys that share CS are not reference-counted: the last event wins.

Read path:
- `kbd[c]` = AND over every row i with `a_hi[i]`=0 of `matrix[i][c]`.
- `a_hi`=FF gives 11111. `a_hi`=00 ANDs all rows together.

## Timing
- Reset: FSM goes to IDLE; flags, timeout counter and filter are cleared; matrix is all 1s.
- Reset values of outputs: `kbd`=11111 for any `a_hi`, `scan_valid`=0, `scancode`=00, `released`=0, `extended`=0, `frame_err`=0.
- Reset asserted mid-frame discards the partial frame with no `frame_err`.
- Edge latency: fe is detected 2 (sync) + `FILTER` cycles after the raw falling edge.
- Byte latency: on the clk edge after the stop-bit fe, the matrix update, `scan_valid`, `scancode`, `released` and `extended` all take effect on the same edge.
- `kbd` is combinational from `a_hi` and the registered matrix. It reflects an update one cycle after the byte is accepted, with zero latency from `a_hi`.
- `frame_err` and a matrix update never occur in the same cycle.
- Reset has priority over everything else.

## Test plan
1. Reset, then send frame 1C with correct parity and stop → `scan_valid` pulses once with `scancode`=1C, `released`=0. With `a_hi`=FD, `kbd`=11110; with `a_hi`=FF, `kbd`=11111.
2. Send F0,1C → `released`=1 and `kbd`=11111 for `a_hi`=FD. Then send E0,6B → `extended`=1; `a_hi`=FE gives 11110 and `a_hi`=F7 gives 01111.
3. Send 1C with wrong parity → `frame_err` pulses and the matrix is unchanged. Send 1C with stop=0 → same result.
4. Send start + 4 data bits, then idle longer than `TIMEOUT` → one `frame_err` pulse and the FSM returns to IDLE. A following valid 29 frame presses SPACE: `a_hi`=7F gives `kbd`=11110.
5. Hold several keys, then send FF → all keys released and `kbd`=11111 for `a_hi`=00, with no `scan_valid`.
6. Hold A (1C) and Q (15), then set `a_hi`=F9 → `kbd`=11110. Also inject a 3-cycle glitch on `ps2clk` with `FILTER`=8 → no bit is sampled.
